ras_sequencer: RTL and testbench
================================

Name: ras_sequencer

Overview:
- Controller for the 16-entry return-address call stack used for jalr prediction.
- Converts fetch-side call/return predictions into stack push/pop commands and tracks speculative vs committed stack depth.
- After a pipeline flush, replays pops or pushes so the stack pointer realigns with committed state.
- Sits between instruction fetch, the commit path and the call stack.

Parameters:
ADDR_W, 17, width of return addresses
DEPTH, 16, number of stack entries; stack pointer wraps mod DEPTH
CNT_W, 8, width of the wrapping speculative/commit event counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
hci_rdy  in  1  global enable; when 0, no state changes and stk_in_en=0
flush  in  1  mispredict flush; discards speculative stack ops
fetch_call  in  1  fetched instruction is a call
fetch_ret  in  1  fetched instruction is a return
fetch_link  in  ADDR_W  link address to push on call
commit_call  in  1  a call committed
commit_ret  in  1  a return committed
fetch_stall  out  1  fetch must hold its current instruction
stk_in_en  out  1  stack command valid
stk_push_mode  out  1  1=push, 0=pop
stk_push_addr  out  ADDR_W  address to push
stk_top  in  ADDR_W  current top from stack
pred_valid  out  1  pred_addr is usable
pred_addr  out  ADDR_W  predicted return target (=stk_top)
recovering  out  1  FSM in RECOVER
spec_depth  out  5  saturating speculative depth, 0..DEPTH
commit_depth  out  5  saturating committed depth, 0..DEPTH

Behaviour:
- Reset (rst=0, async): state=IDLE; spec_cnt=commit_cnt=0; spec_depth=commit_depth=0; held link register=0. All outputs 0.
- All inputs are sampled only when hci_rdy=1. When hci_rdy=0, counters, FSM state and outputs hold, and stk_in_en=0.
- Stack outputs are combinational from state and inputs, giving zero-cycle latency: an event in cycle N drives a stack command in cycle N.
- IDLE, call only: push fetch_link; spec_cnt+1; spec_depth+1, saturating at DEPTH.
- IDLE, ret only: pop; spec_cnt-1; spec_depth-1, saturating at 0.
- IDLE, pop with spec_depth=0: the pop is still issued (the stack wraps), but pred_valid=0.
- IDLE, call and ret together: issue the pop this cycle, latch fetch_link, assert fetch_stall, go to SWAP.
- SWAP: push the latched link, fetch_stall=1, fetch events ignored, return to IDLE. Net spec_cnt change is 0; spec_depth = max(d-1,0)+1.
- Commit events: commit_cnt and commit_depth update in every state, including the flush cycle. Call and ret together net to 0.
- flush (any state, wins over fetch events that cycle):
  - Compute diff = spec_cnt - commit_cnt as signed CNT_W, using the commit values after this cycle's update.
  - diff=0: IDLE, no command.
  - Otherwise go to RECOVER and drop any SWAP in progress.
  - If flush arrives in the SWAP cycle, that cycle's push is not issued and spec_cnt is not changed.
- RECOVER: fetch_stall=1; recovering=1; each hci_rdy cycle re-evaluate diff against the live commit_cnt.
  - diff>0: pop, spec_cnt-1.
  - diff<0: push 0, spec_cnt+1. Lost entries are filled with 0.
  - diff=0: no command; spec_depth<=commit_depth; go to IDLE.
- A second flush during RECOVER: no special action, since the target is already the commit counter.
- pred_valid = (state==IDLE) && !flush && spec_depth!=0. pred_addr = stk_top.
- Depths above DEPTH saturate at DEPTH. The wrapped stack content is then inaccurate, which is accepted.
- Counters wrap mod 2^CNT_W. |diff| must stay < 2^(CNT_W-1); guaranteed by ROB size.

Decomposition:
- Shared package holds: ADDR_W, DEPTH, CNT_W constants, and a state enum IDLE=0, SWAP=1, RECOVER=2.
- Single module. Depth saturation logic may be a small function.
- No sub-module: the stack itself is instantiated alongside by the fetch unit, not inside this block.

Test Plan:
- Reset, then 3 fetch_call with links 0x100/0x200/0x300 -> 3 pushes in consecutive cycles; spec_depth=3; pred_valid=1.
- Then fetch_ret -> same-cycle pop; spec_depth=2; no stall.
- fetch_call and fetch_ret together, link 0x444 -> cycle N: pop, fetch_stall=1; cycle N+1: push 0x444, state returns to IDLE; spec_depth unchanged.
- 2 commit_call, 5 fetch_call, then flush -> RECOVER for 3 pops, then IDLE; spec_depth=2; recovering high for exactly 4 cycles.
- commit 3 calls, 2 fetch_ret (spec below commit), flush -> 2 pushes of 0; spec_depth=3.
- hci_rdy=0 during RECOVER -> no stk_in_en and no counter change. Async rst=0 mid-RECOVER -> immediately all outputs 0, state IDLE.
- fetch_ret at depth 0 -> pop issued; spec_depth stays 0; pred_valid=0.

Source files
------------

// File: rtl/ras_sequencer_pkg.sv
// Shared constants and state encoding for the return-address stack sequencer.
package ras_sequencer_pkg;

    localparam int ADDR_W = 17;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 8;

    localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SWAP    = 2'd1,
        RECOVER = 2'd2
    } state_t;

endpackage

// File: rtl/ras_sequencer.sv
// Turns fetch call/return predictions into call-stack push/pop commands and
// replays stack operations after a flush so the stack realigns with commit.
module ras_sequencer
    import ras_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hci_rdy,
    input  logic              flush,
    input  logic              fetch_call,
    input  logic              fetch_ret,
    input  logic [ADDR_W-1:0] fetch_link,
    input  logic              commit_call,
    input  logic              commit_ret,
    output logic              fetch_stall,
    output logic              stk_in_en,
    output logic              stk_push_mode,
    output logic [ADDR_W-1:0] stk_push_addr,
    input  logic [ADDR_W-1:0] stk_top,
    output logic              pred_valid,
    output logic [ADDR_W-1:0] pred_addr,
    output logic              recovering,
    output logic [4:0]        spec_depth,
    output logic [4:0]        commit_depth
);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        spec_cnt, spec_cnt_nxt;
    logic [CNT_W-1:0]        commit_cnt, commit_cnt_nxt;
    logic [4:0]              spec_dep, spec_dep_nxt;
    logic [4:0]              commit_dep, commit_dep_nxt;
    logic [ADDR_W-1:0]       link_q, link_nxt;
    logic signed [CNT_W-1:0] diff;
    logic                    diff_zero, diff_neg;
    logic                    cmd_en, cmd_push, stall;
    logic [ADDR_W-1:0]       cmd_addr;

    // Saturating depth update; simultaneous inc/dec nets to no change.
    function automatic logic [4:0] depth_step(input logic [4:0] d,
                                              input logic inc,
                                              input logic dec);
        logic [4:0] r;
        r = d;
        if (inc && !dec && d < DEPTH_MAX)
            r = d + 5'd1;
        else if (dec && !inc && d != 5'd0)
            r = d - 5'd1;
        return r;
    endfunction

    always_comb begin
        state_nxt      = state;
        spec_cnt_nxt   = spec_cnt;
        commit_cnt_nxt = commit_cnt;
        spec_dep_nxt   = spec_dep;
        commit_dep_nxt = commit_dep;
        link_nxt       = link_q;
        cmd_en         = 1'b0;
        cmd_push       = 1'b0;
        cmd_addr       = '0;
        stall          = (state != IDLE);
        diff           = '0;
        diff_zero      = 1'b1;
        diff_neg       = 1'b0;

        if (hci_rdy) begin
            if (commit_call && !commit_ret)
                commit_cnt_nxt = commit_cnt + CNT_W'(1);
            else if (commit_ret && !commit_call)
                commit_cnt_nxt = commit_cnt - CNT_W'(1);
            commit_dep_nxt = depth_step(commit_dep, commit_call, commit_ret);

            // Distance to committed state, measured after this cycle's commits.
            diff      = $signed(spec_cnt - commit_cnt_nxt);
            diff_zero = (diff == '0);
            diff_neg  = diff[CNT_W-1];

            case (state)
                IDLE: begin
                    if (flush) begin
                        state_nxt = diff_zero ? IDLE : RECOVER;
                    end else if (fetch_call && fetch_ret) begin
                        cmd_en       = 1'b1;
                        spec_cnt_nxt = spec_cnt - CNT_W'(1);
                        spec_dep_nxt = depth_step(spec_dep, 1'b0, 1'b1);
                        link_nxt     = fetch_link;
                        stall        = 1'b1;
                        state_nxt    = SWAP;
                    end else if (fetch_call) begin
                        cmd_en       = 1'b1;
                        cmd_push     = 1'b1;
                        cmd_addr     = fetch_link;
                        spec_cnt_nxt = spec_cnt + CNT_W'(1);
                        spec_dep_nxt = depth_step(spec_dep, 1'b1, 1'b0);
                    end else if (fetch_ret) begin
                        cmd_en       = 1'b1;
                        spec_cnt_nxt = spec_cnt - CNT_W'(1);
                        spec_dep_nxt = depth_step(spec_dep, 1'b0, 1'b1);
                    end
                end
                SWAP: begin
                    if (flush) begin
                        state_nxt = diff_zero ? IDLE : RECOVER;
                    end else begin
                        cmd_en       = 1'b1;
                        cmd_push     = 1'b1;
                        cmd_addr     = link_q;
                        spec_cnt_nxt = spec_cnt + CNT_W'(1);
                        spec_dep_nxt = depth_step(spec_dep, 1'b1, 1'b0);
                        state_nxt    = IDLE;
                    end
                end
                RECOVER: begin
                    // A repeated flush needs nothing extra: the target is already commit.
                    if (diff_zero) begin
                        spec_dep_nxt = commit_dep_nxt;
                        state_nxt    = IDLE;
                    end else if (diff_neg) begin
                        cmd_en       = 1'b1;
                        cmd_push     = 1'b1;
                        spec_cnt_nxt = spec_cnt + CNT_W'(1);
                    end else begin
                        cmd_en       = 1'b1;
                        spec_cnt_nxt = spec_cnt - CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            spec_cnt   <= '0;
            commit_cnt <= '0;
            spec_dep   <= '0;
            commit_dep <= '0;
            link_q     <= '0;
        end else begin
            state      <= state_nxt;
            spec_cnt   <= spec_cnt_nxt;
            commit_cnt <= commit_cnt_nxt;
            spec_dep   <= spec_dep_nxt;
            commit_dep <= commit_dep_nxt;
            link_q     <= link_nxt;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign stk_in_en     = rst & cmd_en;
    assign stk_push_mode = rst & cmd_push;
    assign stk_push_addr = rst ? cmd_addr : '0;
    assign fetch_stall   = rst & stall;
    assign recovering    = rst & (state == RECOVER);
    assign pred_valid    = rst & (state == IDLE) & ~flush & (spec_dep != 5'd0);
    assign pred_addr     = rst ? stk_top : '0;
    assign spec_depth    = spec_dep;
    assign commit_depth  = commit_dep;

endmodule

// File: tb/tb_ras_sequencer.sv
// Directed and randomized checks of ras_sequencer against a call-counting
// reference model with its own 16-entry stack driving stk_top.
module tb_ras_sequencer;

    logic        clk = 1'b0;
    logic        rst, hci_rdy, flush, fetch_call, fetch_ret, commit_call, commit_ret;
    logic [16:0] fetch_link, stk_top, stk_push_addr, pred_addr;
    logic        fetch_stall, stk_in_en, stk_push_mode, pred_valid, recovering;
    logic [4:0]  spec_depth, commit_depth;
    logic [48:0] all_out;

    int vectors = 0;
    int miscompares = 0;

    logic [16:0] stk_mem [16];
    logic [3:0]  sp;

    // Reference model: unbounded call counts and clamped depths.
    int          m_spec, m_commit, m_sdepth, m_cdepth;
    bit          m_swap, m_recov;
    logic [16:0] m_link;
    int          n_spec, n_commit, n_sdepth, n_cdepth;
    bit          n_swap, n_recov;
    logic [16:0] n_link;

    logic        e_en, e_push, e_stall, e_pv, e_rec;
    logic [16:0] e_addr, e_pa;
    logic [4:0]  e_sd, e_cd;
    logic        o_en, o_push, o_stall, o_pv, o_rec;
    logic [16:0] o_addr, o_pa;
    logic [4:0]  o_sd, o_cd;

    assign stk_top = stk_mem[sp];
    assign all_out = {stk_in_en, stk_push_mode, stk_push_addr, fetch_stall, pred_valid,
                      pred_addr, recovering, spec_depth, commit_depth};

    always #5 clk = ~clk;

    ras_sequencer dut (
        .clk(clk), .rst(rst), .hci_rdy(hci_rdy), .flush(flush),
        .fetch_call(fetch_call), .fetch_ret(fetch_ret), .fetch_link(fetch_link),
        .commit_call(commit_call), .commit_ret(commit_ret),
        .fetch_stall(fetch_stall), .stk_in_en(stk_in_en), .stk_push_mode(stk_push_mode),
        .stk_push_addr(stk_push_addr), .stk_top(stk_top), .pred_valid(pred_valid),
        .pred_addr(pred_addr), .recovering(recovering),
        .spec_depth(spec_depth), .commit_depth(commit_depth)
    );

    function automatic int clamp16(input int v);
        return (v < 0) ? 0 : ((v > 16) ? 16 : v);
    endfunction

    function automatic void model_reset();
        m_spec = 0; m_commit = 0; m_sdepth = 0; m_cdepth = 0;
        m_swap = 0; m_recov = 0; m_link = '0;
    endfunction

    function automatic void model_eval();
        int delta, gap;
        n_spec = m_spec; n_commit = m_commit; n_sdepth = m_sdepth; n_cdepth = m_cdepth;
        n_swap = m_swap; n_recov = m_recov; n_link = m_link;
        e_en = 0; e_push = 0; e_addr = '0;
        e_rec   = m_recov;
        e_stall = m_swap || m_recov;
        e_pv    = !m_swap && !m_recov && !flush && (m_sdepth != 0);
        e_sd    = 5'(m_sdepth);
        e_cd    = 5'(m_cdepth);
        e_pa    = stk_top;
        if (!rst) begin
            e_rec = 0; e_stall = 0; e_pv = 0; e_sd = '0; e_cd = '0; e_pa = '0;
            n_spec = 0; n_commit = 0; n_sdepth = 0; n_cdepth = 0;
            n_swap = 0; n_recov = 0; n_link = '0;
            return;
        end
        if (!hci_rdy) return;
        delta    = int'(commit_call) - int'(commit_ret);
        n_commit = m_commit + delta;
        n_cdepth = clamp16(m_cdepth + delta);
        if (m_recov) begin
            gap = m_spec - n_commit;
            if (gap > 0) begin
                e_en = 1; n_spec = m_spec - 1;
            end else if (gap < 0) begin
                e_en = 1; e_push = 1; n_spec = m_spec + 1;
            end else begin
                n_sdepth = n_cdepth; n_recov = 0;
            end
        end else if (flush) begin
            n_swap = 0;
            n_recov = (m_spec != n_commit);
        end else if (m_swap) begin
            e_en = 1; e_push = 1; e_addr = m_link;
            n_spec = m_spec + 1; n_sdepth = clamp16(m_sdepth + 1); n_swap = 0;
        end else if (fetch_call && fetch_ret) begin
            e_en = 1; e_stall = 1;
            n_spec = m_spec - 1; n_sdepth = clamp16(m_sdepth - 1);
            n_link = fetch_link; n_swap = 1;
        end else if (fetch_call) begin
            e_en = 1; e_push = 1; e_addr = fetch_link;
            n_spec = m_spec + 1; n_sdepth = clamp16(m_sdepth + 1);
        end else if (fetch_ret) begin
            e_en = 1;
            n_spec = m_spec - 1; n_sdepth = clamp16(m_sdepth - 1);
        end
    endfunction

    function automatic void model_commit();
        m_spec = n_spec; m_commit = n_commit; m_sdepth = n_sdepth; m_cdepth = n_cdepth;
        m_swap = n_swap; m_recov = n_recov; m_link = n_link;
        if (e_en) begin
            if (e_push) begin
                sp = sp + 4'd1;
                stk_mem[sp] = e_addr;
            end else begin
                sp = sp - 4'd1;
            end
        end
    endfunction

    task automatic idle_inputs();
        hci_rdy = 1; flush = 0; fetch_call = 0; fetch_ret = 0;
        commit_call = 0; commit_ret = 0; fetch_link = '0;
    endtask

    // One clock: sample outputs mid-cycle, advance model at the edge.
    task automatic cycle();
        @(negedge clk);
        o_en = stk_in_en; o_push = stk_push_mode; o_addr = stk_push_addr;
        o_stall = fetch_stall; o_pv = pred_valid; o_pa = pred_addr;
        o_rec = recovering; o_sd = spec_depth; o_cd = commit_depth;
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0; hci_rdy = 1; flush = 0; fetch_call = 1; fetch_ret = 0;
        fetch_link = 17'h1abcd; commit_call = 1; commit_ret = 0;
        #2;
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, want 0", all_out);
        end
        cycle();
        cycle();
        vectors++;
        if ({spec_depth, commit_depth, recovering, stk_in_en} !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_hold: got sd=%0d cd=%0d rec=%0b en=%0b, want 0", spec_depth,
                     commit_depth, recovering, stk_in_en);
        end
        idle_inputs();
        rst = 1;
    endtask

    task automatic test_calls();
        logic [16:0] link;
        for (int i = 0; i < 3; i++) begin
            link = 17'((i + 1) * 'h100);
            fetch_call = 1; fetch_link = link;
            cycle();
            vectors++;
            if ({o_en, o_push, o_stall, o_addr} !== {1'b1, 1'b1, 1'b0, link}) begin
                miscompares++;
                $display("FAIL calls_push%0d: got en=%0b push=%0b stall=%0b addr=%h, want 1 1 0 %h",
                         i, o_en, o_push, o_stall, o_addr, link);
            end
        end
        idle_inputs();
        cycle();
        vectors++;
        if ({o_sd, o_pv, o_pa} !== {5'd3, 1'b1, 17'h300}) begin
            miscompares++;
            $display("FAIL calls_depth: got sd=%0d pv=%0b pa=%h, want 3 1 300", o_sd, o_pv, o_pa);
        end
    endtask

    task automatic test_ret();
        fetch_ret = 1;
        cycle();
        vectors++;
        if ({o_en, o_push, o_stall, o_pv} !== 4'b1001) begin
            miscompares++;
            $display("FAIL ret_pop: got en=%0b push=%0b stall=%0b pv=%0b, want 1 0 0 1",
                     o_en, o_push, o_stall, o_pv);
        end
        idle_inputs();
        cycle();
        vectors++;
        if (o_sd !== 5'd2) begin
            miscompares++;
            $display("FAIL ret_depth: got %0d, want 2", o_sd);
        end
    endtask

    task automatic test_swap();
        fetch_call = 1; fetch_ret = 1; fetch_link = 17'h444;
        cycle();
        vectors++;
        if ({o_en, o_push, o_stall} !== 3'b101) begin
            miscompares++;
            $display("FAIL swap_pop: got en=%0b push=%0b stall=%0b, want 1 0 1", o_en, o_push, o_stall);
        end
        fetch_ret = 0; fetch_link = 17'h555;
        cycle();
        vectors++;
        if ({o_en, o_push, o_stall, o_pv, o_addr} !== {1'b1, 1'b1, 1'b1, 1'b0, 17'h444}) begin
            miscompares++;
            $display("FAIL swap_push: got en=%0b push=%0b stall=%0b pv=%0b addr=%h, want 1 1 1 0 444",
                     o_en, o_push, o_stall, o_pv, o_addr);
        end
        idle_inputs();
        cycle();
        vectors++;
        if ({o_stall, o_rec, o_sd} !== {1'b0, 1'b0, 5'd2}) begin
            miscompares++;
            $display("FAIL swap_done: got stall=%0b rec=%0b sd=%0d, want 0 0 2", o_stall, o_rec, o_sd);
        end
    endtask

    task automatic test_flush_pop();
        int rec_n, pops, pushes;
        do_reset();
        commit_call = 1;
        repeat (2) cycle();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            fetch_call = 1; fetch_link = 17'($urandom);
            cycle();
        end
        idle_inputs();
        flush = 1;
        cycle();
        vectors++;
        if ({o_en, o_rec} !== 2'b00) begin
            miscompares++;
            $display("FAIL flushpop_flushcycle: got en=%0b rec=%0b, want 0 0", o_en, o_rec);
        end
        flush = 0;
        rec_n = 0; pops = 0; pushes = 0;
        repeat (10) begin
            cycle();
            rec_n += int'(o_rec);
            if (o_en && !o_push) pops++;
            if (o_en && o_push) pushes++;
        end
        vectors++;
        if (rec_n != 4 || pops != 3 || pushes != 0 || o_sd !== 5'd2 || o_cd !== 5'd2) begin
            miscompares++;
            $display("FAIL flushpop_recover: got rec=%0d pops=%0d pushes=%0d sd=%0d cd=%0d, want 4 3 0 2 2",
                     rec_n, pops, pushes, o_sd, o_cd);
        end
    endtask

    task automatic test_flush_push();
        int rec_n, zpush, other;
        do_reset();
        fetch_call = 1;
        repeat (3) cycle();
        idle_inputs();
        commit_call = 1;
        repeat (3) cycle();
        idle_inputs();
        fetch_ret = 1;
        repeat (2) cycle();
        idle_inputs();
        flush = 1;
        cycle();
        flush = 0;
        rec_n = 0; zpush = 0; other = 0;
        repeat (10) begin
            cycle();
            rec_n += int'(o_rec);
            if (o_en && o_push && o_addr === '0) zpush++;
            else if (o_en) other++;
        end
        vectors++;
        if (rec_n != 3 || zpush != 2 || other != 0 || o_sd !== 5'd3) begin
            miscompares++;
            $display("FAIL flushpush_recover: got rec=%0d zpush=%0d other=%0d sd=%0d, want 3 2 0 3",
                     rec_n, zpush, other, o_sd);
        end
    endtask

    task automatic test_flush_in_swap();
        int rec_n, zpush, other;
        do_reset();
        fetch_call = 1; commit_call = 1;
        repeat (2) cycle();
        idle_inputs();
        fetch_call = 1; fetch_ret = 1; fetch_link = 17'h7f;
        cycle();
        idle_inputs();
        flush = 1;
        cycle();
        vectors++;
        if ({o_en, o_stall} !== 2'b01) begin
            miscompares++;
            $display("FAIL swapflush_cycle: got en=%0b stall=%0b, want 0 1", o_en, o_stall);
        end
        flush = 0;
        rec_n = 0; zpush = 0; other = 0;
        repeat (8) begin
            cycle();
            rec_n += int'(o_rec);
            if (o_en && o_push && o_addr === '0) zpush++;
            else if (o_en) other++;
        end
        vectors++;
        if (rec_n != 2 || zpush != 1 || other != 0 || o_sd !== 5'd2) begin
            miscompares++;
            $display("FAIL swapflush_recover: got rec=%0d zpush=%0d other=%0d sd=%0d, want 2 1 0 2",
                     rec_n, zpush, other, o_sd);
        end
    endtask

    task automatic test_rdy_hold();
        do_reset();
        fetch_call = 1;
        repeat (4) cycle();
        idle_inputs();
        flush = 1;
        cycle();
        flush = 0;
        cycle();
        vectors++;
        if ({o_en, o_push, o_rec} !== 3'b101) begin
            miscompares++;
            $display("FAIL hold_firstpop: got en=%0b push=%0b rec=%0b, want 1 0 1", o_en, o_push, o_rec);
        end
        hci_rdy = 0; commit_call = 1; flush = 1; fetch_call = 1; fetch_link = 17'h1f0f0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if ({o_en, o_rec, o_stall} !== 3'b011) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got en=%0b rec=%0b stall=%0b, want 0 1 1",
                         i, o_en, o_rec, o_stall);
            end
        end
        vectors++;
        if ({o_sd, o_cd} !== {5'd4, 5'd0}) begin
            miscompares++;
            $display("FAIL hold_depths: got sd=%0d cd=%0d, want 4 0", o_sd, o_cd);
        end
        idle_inputs();
        cycle();
        vectors++;
        if ({o_en, o_push, o_rec} !== 3'b101) begin
            miscompares++;
            $display("FAIL hold_resume: got en=%0b push=%0b rec=%0b, want 1 0 1", o_en, o_push, o_rec);
        end
        fetch_call = 1; fetch_link = 17'h1234f;
        #2;
        rst = 0;
        #1;
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %h, want 0", all_out);
        end
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_ret_empty();
        do_reset();
        fetch_ret = 1;
        cycle();
        vectors++;
        if ({o_en, o_push, o_pv} !== 3'b100) begin
            miscompares++;
            $display("FAIL empty_pop: got en=%0b push=%0b pv=%0b, want 1 0 0", o_en, o_push, o_pv);
        end
        idle_inputs();
        cycle();
        vectors++;
        if ({o_sd, o_pv} !== {5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL empty_depth: got sd=%0d pv=%0b, want 0 0", o_sd, o_pv);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            fetch_call = 1; commit_call = 1; fetch_link = 17'($urandom);
            cycle();
        end
        idle_inputs();
        cycle();
        vectors++;
        if ({o_sd, o_cd} !== {5'd16, 5'd16}) begin
            miscompares++;
            $display("FAIL sat_depths: got sd=%0d cd=%0d, want 16 16", o_sd, o_cd);
        end
        flush = 1;
        cycle();
        flush = 0;
        cycle();
        vectors++;
        if ({o_en, o_rec, o_stall} !== 3'b000) begin
            miscompares++;
            $display("FAIL sat_flush_aligned: got en=%0b rec=%0b stall=%0b, want 0 0 0",
                     o_en, o_rec, o_stall);
        end
        fetch_ret = 1;
        cycle();
        idle_inputs();
        cycle();
        vectors++;
        if (o_sd !== 5'd15) begin
            miscompares++;
            $display("FAIL sat_ret: got sd=%0d, want 15", o_sd);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            hci_rdy     = ($urandom_range(0, 99) < 85);
            flush       = ($urandom_range(0, 99) < 4);
            fetch_call  = ($urandom_range(0, 99) < 35);
            fetch_ret   = ($urandom_range(0, 99) < 30);
            commit_call = ($urandom_range(0, 99) < 25);
            commit_ret  = ($urandom_range(0, 99) < 20);
            fetch_link  = 17'($urandom);
            if (!m_recov && (m_spec - m_commit > 40 || m_commit - m_spec > 40)) begin
                hci_rdy = 1; flush = 1;
            end
            cycle();
            vectors++;
            if ({o_en, o_stall, o_pv, o_rec, o_sd, o_cd, o_pa} !==
                {e_en, e_stall, e_pv, e_rec, e_sd, e_cd, e_pa}) begin
                miscompares++;
                $display("FAIL rand%0d: got en=%0b stall=%0b pv=%0b rec=%0b sd=%0d cd=%0d pa=%h, want %0b %0b %0b %0b %0d %0d %h",
                         n, o_en, o_stall, o_pv, o_rec, o_sd, o_cd, o_pa,
                         e_en, e_stall, e_pv, e_rec, e_sd, e_cd, e_pa);
            end
            if (e_en) begin
                vectors++;
                if ({o_push, o_addr} !== {e_push, e_addr}) begin
                    miscompares++;
                    $display("FAIL rand%0d_cmd: got push=%0b addr=%h, want %0b %h",
                             n, o_push, o_addr, e_push, e_addr);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) stk_mem[i] = 17'($urandom_range(1, 'h1ffff));
        sp = '0;
        model_reset();
        rst = 0;
        idle_inputs();
        test_reset();
        test_calls();
        test_ret();
        test_swap();
        test_flush_pop();
        test_flush_push();
        test_flush_in_swap();
        test_rdy_hold();
        test_ret_empty();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
